// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit 5-stage pipeline: opcodes, branch condition codes,
// flag bit positions and flag-update classification helpers.
package pipe_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_RED    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LHB    = 4'b1010;
    localparam logic [3:0] OP_LLB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GE     = 3'b100;
    localparam logic [2:0] CC_LE     = 3'b101;
    localparam logic [2:0] CC_OV     = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 2;

    function automatic logic is_flag_zvn(logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_flag_z(logic [3:0] op);
        return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluator: decides whether a condition code is met
// by a given Z/V/N flag set. Shared between ID and the EX/MEM forwarding path.
module branch_cond
    import pipe_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z, v, n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE:     taken = ~z;
            CC_EQ:     taken = z;
            CC_GT:     taken = ~z & ~n;
            CC_LT:     taken = n;
            CC_GE:     taken = z | (~z & ~n);
            CC_LE:     taken = n | z;
            CC_OV:     taken = v;
            CC_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Owns the architectural Z/V/N flags, forwards the
// would-be flag value to the ID branch evaluator, and latches a sticky halt.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_result,
    input  logic [DW-1:0] ex_mem_addr,
    input  logic [DW-1:0] ex_store_data,
    input  logic [2:0]    ex_flag,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic [2:0]    id_ccc,
    output logic          mem_valid,
    output logic [3:0]    mem_opcode,
    output logic [DW-1:0] mem_result,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_rd,
    output logic          mem_regwrite,
    output logic          mem_memread,
    output logic          mem_memwrite,
    output logic [2:0]    flag_q,
    output logic          branch_taken,
    output logic          halted
);

    logic       accept;
    logic       no_wb;
    logic [2:0] flag_d;

    assign accept = ex_valid & ~stall & ~flush & ~halted;
    assign no_wb  = (ex_opcode == OP_SW) | (ex_opcode == OP_B) |
                    (ex_opcode == OP_BR) | (ex_opcode == OP_HLT);

    // flag_d doubles as the forwarded flag set: it equals flag_q unless accepted.
    always_comb begin
        flag_d = flag_q;
        if (accept) begin
            if (is_flag_zvn(ex_opcode)) begin
                flag_d = ex_flag;
            end else if (is_flag_z(ex_opcode)) begin
                flag_d[FLAG_Z] = ex_flag[FLAG_Z];
            end
        end
    end

    branch_cond u_branch_cond (
        .ccc   (id_ccc),
        .flags (flag_d),
        .taken (branch_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_opcode     <= '0;
            mem_result     <= '0;
            mem_addr       <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            flag_q         <= 3'b000;
            halted         <= 1'b0;
        end else if (!stall) begin
            // Data fields load unconditionally; they are ignored whenever mem_valid is 0.
            mem_valid      <= accept;
            mem_opcode     <= ex_opcode;
            mem_result     <= ex_result;
            mem_addr       <= ex_mem_addr;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_regwrite   <= accept & ex_regwrite & ~no_wb;
            mem_memread    <= accept & (ex_opcode == OP_LW);
            mem_memwrite   <= accept & (ex_opcode == OP_SW);
            flag_q         <= flag_d;
            halted         <= halted | (accept & (ex_opcode == OP_HLT));
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a vector table for single-cycle behaviour plus
// hand sequences for stall/flush priority, halt and asynchronous reset.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, ex_valid, ex_regwrite;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result, ex_mem_addr, ex_store_data;
    logic [2:0]  ex_flag, id_ccc;
    logic [3:0]  ex_rd;
    logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite;
    logic [3:0]  mem_opcode, mem_rd;
    logic [15:0] mem_result, mem_addr, mem_store_data;
    logic [2:0]  flag_q;
    logic        branch_taken, halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DW(16), .RW(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_result      (ex_result),
        .ex_mem_addr    (ex_mem_addr),
        .ex_store_data  (ex_store_data),
        .ex_flag        (ex_flag),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .id_ccc         (id_ccc),
        .mem_valid      (mem_valid),
        .mem_opcode     (mem_opcode),
        .mem_result     (mem_result),
        .mem_addr       (mem_addr),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .flag_q         (flag_q),
        .branch_taken   (branch_taken),
        .halted         (halted)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [3:0]  op;
        logic [15:0] res;
        logic [15:0] addr;
        logic [2:0]  flag;
        logic [3:0]  rd;
        logic        rw;
        logic [2:0]  ccc;
        logic        e_taken;
        logic        e_mv;
        logic        e_rw;
        logic        e_mr;
        logic        e_mw;
        logic [2:0]  e_flag;
        logic        chk_data;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic v, input logic [3:0] op,
                         input logic [15:0] res, input logic [15:0] addr, input logic [2:0] fg,
                         input logic [3:0] rd, input logic rw, input logic [2:0] ccc);
        stall = st; flush = fl; ex_valid = v; ex_opcode = op;
        ex_result = res; ex_mem_addr = addr; ex_store_data = res ^ 16'hA5A5;
        ex_flag = fg; ex_rd = rd; ex_regwrite = rw; id_ccc = ccc;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mv"},   {31'd0, mem_valid}, 32'd0);
        chk({tag, "_rw"},   {31'd0, mem_regwrite}, 32'd0);
        chk({tag, "_mr"},   {31'd0, mem_memread}, 32'd0);
        chk({tag, "_mw"},   {31'd0, mem_memwrite}, 32'd0);
        chk({tag, "_op"},   {28'd0, mem_opcode}, 32'd0);
        chk({tag, "_res"},  {16'd0, mem_result}, 32'd0);
        chk({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({tag, "_sd"},   {16'd0, mem_store_data}, 32'd0);
        chk({tag, "_rd"},   {28'd0, mem_rd}, 32'd0);
        chk({tag, "_flag"}, {29'd0, flag_q}, 32'd0);
        chk({tag, "_halt"}, {31'd0, halted}, 32'd0);
    endtask

    initial begin
        //          st  fl  v   op       res       addr      flag    rd    rw  ccc     tk  mv  rw  mr  mw  eflag   data
        vecs[0]  = '{1'b0,1'b0,1'b1,4'b0000,16'h0000,16'h0000,3'b001,4'd3,1'b1,3'b001, 1'b1,1'b1,1'b1,1'b0,1'b0,3'b001,1'b1};
        vecs[1]  = '{1'b0,1'b0,1'b1,4'b0011,16'h00FF,16'h0010,3'b110,4'd4,1'b1,3'b000, 1'b1,1'b1,1'b1,1'b0,1'b0,3'b000,1'b1};
        // Stalled SUB: no forwarding, everything holds from the XOR above.
        vecs[2]  = '{1'b1,1'b0,1'b1,4'b0001,16'h0000,16'h0020,3'b001,4'd5,1'b1,3'b001, 1'b0,1'b1,1'b1,1'b0,1'b0,3'b000,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b1,4'b0001,16'h0000,16'h0020,3'b001,4'd5,1'b1,3'b001, 1'b1,1'b1,1'b1,1'b0,1'b0,3'b001,1'b1};
        vecs[4]  = '{1'b0,1'b0,1'b1,4'b1011,16'h0055,16'h0030,3'b111,4'd6,1'b1,3'b110, 1'b0,1'b1,1'b1,1'b0,1'b0,3'b001,1'b1};
        vecs[5]  = '{1'b0,1'b0,1'b1,4'b1001,16'h0BEE,16'h0040,3'b110,4'd7,1'b1,3'b011, 1'b0,1'b1,1'b0,1'b0,1'b1,3'b001,1'b1};
        vecs[6]  = '{1'b0,1'b0,1'b1,4'b1000,16'h0000,16'h1234,3'b000,4'd8,1'b1,3'b010, 1'b0,1'b1,1'b1,1'b1,1'b0,3'b001,1'b1};
        vecs[7]  = '{1'b0,1'b0,1'b1,4'b0101,16'h8001,16'h0050,3'b100,4'd9,1'b1,3'b101, 1'b0,1'b1,1'b1,1'b0,1'b0,3'b000,1'b1};
        vecs[8]  = '{1'b0,1'b0,1'b1,4'b0000,16'h9000,16'h0060,3'b110,4'd1,1'b1,3'b100, 1'b0,1'b1,1'b1,1'b0,1'b0,3'b110,1'b1};
        vecs[9]  = '{1'b0,1'b0,1'b0,4'b0000,16'h0000,16'h0070,3'b001,4'd2,1'b1,3'b111, 1'b1,1'b0,1'b0,1'b0,1'b0,3'b110,1'b0};
        vecs[10] = '{1'b0,1'b1,1'b1,4'b0001,16'h0000,16'h0080,3'b001,4'd2,1'b1,3'b011, 1'b1,1'b0,1'b0,1'b0,1'b0,3'b110,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b1,4'b0110,16'h1111,16'h0090,3'b011,4'd3,1'b1,3'b110, 1'b1,1'b1,1'b1,1'b0,1'b0,3'b111,1'b1};
        vecs[12] = '{1'b0,1'b0,1'b1,4'b1101,16'h2222,16'h00A0,3'b000,4'd4,1'b1,3'b000, 1'b0,1'b1,1'b0,1'b0,1'b0,3'b111,1'b1};
        vecs[13] = '{1'b0,1'b0,1'b1,4'b0111,16'h3333,16'h00B0,3'b000,4'd5,1'b1,3'b001, 1'b1,1'b1,1'b1,1'b0,1'b0,3'b111,1'b1};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0, 16'h0, 3'b000, 4'd0, 1'b0, 3'b000);
        #2;
        check_reset_state("rst0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].op, vecs[i].res,
                  vecs[i].addr, vecs[i].flag, vecs[i].rd, vecs[i].rw, vecs[i].ccc);
            #1;
            chk($sformatf("v%0d_taken", i), {31'd0, branch_taken}, {31'd0, vecs[i].e_taken});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_mv", i), {31'd0, mem_valid}, {31'd0, vecs[i].e_mv});
            chk($sformatf("v%0d_rw", i), {31'd0, mem_regwrite}, {31'd0, vecs[i].e_rw});
            chk($sformatf("v%0d_mr", i), {31'd0, mem_memread}, {31'd0, vecs[i].e_mr});
            chk($sformatf("v%0d_mw", i), {31'd0, mem_memwrite}, {31'd0, vecs[i].e_mw});
            chk($sformatf("v%0d_flag", i), {29'd0, flag_q}, {29'd0, vecs[i].e_flag});
            chk($sformatf("v%0d_halt", i), {31'd0, halted}, 32'd0);
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_op", i), {28'd0, mem_opcode}, {28'd0, vecs[i].op});
                chk($sformatf("v%0d_res", i), {16'd0, mem_result}, {16'd0, vecs[i].res});
                chk($sformatf("v%0d_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].addr});
                chk($sformatf("v%0d_sd", i), {16'd0, mem_store_data},
                    {16'd0, vecs[i].res ^ 16'hA5A5});
                chk($sformatf("v%0d_rd", i), {28'd0, mem_rd}, {28'd0, vecs[i].rd});
            end
        end

        // Stall beats flush: the PADDSB from the last vector must stay in MEM.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 4'b1000, 16'h0000, 16'h1234, 3'b001, 4'd9, 1'b1, 3'b000);
        @(posedge clk);
        #1;
        chk("sf_mv",   {31'd0, mem_valid}, 32'd1);
        chk("sf_op",   {28'd0, mem_opcode}, 32'h7);
        chk("sf_addr", {16'd0, mem_addr}, 32'h00B0);
        chk("sf_mr",   {31'd0, mem_memread}, 32'd0);
        chk("sf_flag", {29'd0, flag_q}, 32'h7);
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("fl_mv",   {31'd0, mem_valid}, 32'd0);
        chk("fl_mr",   {31'd0, mem_memread}, 32'd0);
        chk("fl_flag", {29'd0, flag_q}, 32'h7);

        // Halt: HLT enters MEM valid, then everything after is a bubble with frozen flags.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 4'b1111, 16'h0000, 16'h0000, 3'b000, 4'd1, 1'b1, 3'b000);
        @(posedge clk);
        #1;
        chk("hlt_halt", {31'd0, halted}, 32'd1);
        chk("hlt_mv",   {31'd0, mem_valid}, 32'd1);
        chk("hlt_op",   {28'd0, mem_opcode}, 32'hF);
        chk("hlt_rw",   {31'd0, mem_regwrite}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b1, 4'b0000, 16'h4444, 16'h0000, 3'b000, 4'd2, 1'b1, 3'b000);
            #1;
            chk($sformatf("hz%0d_taken", k), {31'd0, branch_taken}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("hz%0d_mv", k),   {31'd0, mem_valid}, 32'd0);
            chk($sformatf("hz%0d_rw", k),   {31'd0, mem_regwrite}, 32'd0);
            chk($sformatf("hz%0d_flag", k), {29'd0, flag_q}, 32'h7);
            chk($sformatf("hz%0d_halt", k), {31'd0, halted}, 32'd1);
        end

        // Mid-cycle asynchronous reset clears everything before any edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst1");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 16'h0000, 3'b001, 4'd3, 1'b1, 3'b001);
        @(posedge clk);
        #1;
        chk("post_mv",   {31'd0, mem_valid}, 32'd1);
        chk("post_flag", {29'd0, flag_q}, 32'h1);
        chk("post_halt", {31'd0, halted}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
